// File: rtl/gpio_reg_master.sv
// ============================================================================
// Module   : gpio_reg_master
// Brief    : Command-driven initiator for the GPIO register bus, with atomic
//            SET/CLR/TGL by read-modify-write and one response per command.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_reg_master #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter int                CNT_W     = 16,
  parameter logic [ADDR_W-1:0] DATA_ADDR = 'h00,
  parameter logic [ADDR_W-1:0] DIR_ADDR  = 'h04
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_CLR   = 3'd3;
  localparam logic [2:0] OP_TGL   = 3'd4;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rd_q;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic [CNT_W-1:0]  r_txn_cnt;
  logic              w_accept;
  logic              w_acc_err;
  logic              w_hshake;
  logic [DATA_W-1:0] w_wval;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign w_hshake  = rsp_ready && (r_state == S_RESP);
  // Only READ may target an arbitrary address; writes are limited to DATA/DIR.
  assign w_acc_err = (cmd_op > OP_TGL) ||
                     ((cmd_op != OP_READ) && (cmd_addr != DATA_ADDR) && (cmd_addr != DIR_ADDR));

  always_comb begin
    w_wval = r_data;
    case (r_op)
      OP_SET:  w_wval = r_rd_q | r_data;
      OP_CLR:  w_wval = r_rd_q & ~r_data;
      OP_TGL:  w_wval = r_rd_q ^ r_data;
      default: w_wval = r_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_acc_err)             w_next = S_RESP;
          else if (cmd_op == OP_WRITE) w_next = S_WRITE;
          else                       w_next = S_READ;
        end
      end
      S_READ:  w_next = (r_op == OP_READ) ? S_RESP : S_WRITE;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = rsp_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    rsp_valid = (r_state == S_RESP);
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    addr      = '0;
    wdata     = '0;
    case (r_state)
      S_READ: begin
        rd_en = 1'b1;
        addr  = r_addr;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        addr  = r_addr;
        wdata = w_wval;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_q     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_txn_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= cmd_op;
        r_addr     <= cmd_addr;
        r_data     <= cmd_data;
        r_rsp_err  <= w_acc_err;
        r_rsp_data <= '0;
      end
      if (r_state == S_READ) begin
        r_rd_q <= rdata;
        if (r_op == OP_READ) r_rsp_data <= rdata;
      end
      if (r_state == S_WRITE) r_rsp_data <= w_wval;
      if (w_hshake) r_txn_cnt <= r_txn_cnt + 1'b1;
    end
  end

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign txn_cnt  = r_txn_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gpio_reg_master.sv
// ============================================================================
// Module   : tb_gpio_reg_master
// Brief    : Directed scoreboard bench for gpio_reg_master with a GPIO slave model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpio_reg_master;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_ready;
  logic [31:0] rdata;
  logic        cmd_ready, rsp_valid, rsp_err, wr_en, rd_en, busy;
  logic [31:0] rsp_data, wdata;
  logic [7:0]  addr;
  logic [15:0] txn_cnt;
  logic        x_cmd_ready, x_rsp_valid, x_rsp_err, x_wr_en, x_rd_en, x_busy;
  logic [31:0] x_rsp_data, x_wdata;
  logic [7:0]  x_addr;
  logic [2:0]  x_txn_cnt;

  logic [31:0] s_data = 32'h0;
  logic [31:0] s_dir  = 32'h0;
  logic [31:0] gpio_in = 32'h0;
  logic [31:0] m_data = 32'h0;
  logic [31:0] m_dir  = 32'h0;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt   = 0;

  always #5 clk = ~clk;

  gpio_reg_master u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .txn_cnt(txn_cnt)
  );

  // Same stimulus, narrow counter: exposes the all-ones -> 0 wrap within a few commands.
  gpio_reg_master #(.CNT_W(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(x_cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(x_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(x_rsp_data), .rsp_err(x_rsp_err),
    .wr_en(x_wr_en), .rd_en(x_rd_en), .addr(x_addr), .wdata(x_wdata), .rdata(rdata),
    .busy(x_busy), .txn_cnt(x_txn_cnt)
  );

  always_comb begin
    case (addr)
      8'h00:   rdata = s_data;
      8'h04:   rdata = s_dir;
      8'h08:   rdata = gpio_in;
      default: rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (wr_en && addr == 8'h00) s_data <= wdata;
    if (wr_en && addr == 8'h04) s_dir  <= wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [7:0] a);
    case (a)
      8'h00:   return m_data;
      8'h04:   return m_dir;
      8'h08:   return gpio_in;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".strobes"}, {rd_en, wr_en, x_rd_en, x_wr_en}, 0);
    chk({tag, ".addr_wdata"}, {addr, wdata[23:0]} | wdata | x_wdata | x_addr, 0);
    chk({tag, ".txn_cnt"}, txn_cnt, cnt[15:0]);
    chk({tag, ".txn_wrap"}, x_txn_cnt, cnt[2:0]);
    chk({tag, ".x_ready_busy"}, {x_cmd_ready, x_busy, x_rsp_valid}, 3'b100);
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [31:0] d, input int hold);
    logic        err;
    int          k_rd, k_wr, k_rsp;
    logic [31:0] wd, old, res;
    rsp_t        exp;
    err  = (op > 3'd4) || (op != 3'd1 && a != 8'h00 && a != 8'h04);
    k_rd = 0; k_wr = 0; k_rsp = 1; wd = 32'h0; res = 32'h0;
    old  = mread(a);
    if (!err) begin
      case (op)
        3'd0: begin k_wr = 1; k_rsp = 2; wd = d; end
        3'd1: begin k_rd = 1; k_rsp = 2; res = old; end
        3'd2: begin k_rd = 1; k_wr = 2; k_rsp = 3; wd = old | d; end
        3'd3: begin k_rd = 1; k_wr = 2; k_rsp = 3; wd = old & ~d; end
        default: begin k_rd = 1; k_wr = 2; k_rsp = 3; wd = old ^ d; end
      endcase
      if (op != 3'd1) begin
        res = wd;
        if (a == 8'h00) m_data = wd;
        else            m_dir  = wd;
      end
    end
    sb_q.push_back('{err: err, data: res});

    chk({tag, ".ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    for (int k = 1; k < k_rsp; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, ".rd_en"}, {rd_en, x_rd_en}, (k == k_rd) ? 2'b11 : 2'b00);
      chk({tag, ".wr_en"}, {wr_en, x_wr_en}, (k == k_wr) ? 2'b11 : 2'b00);
      chk({tag, ".addr"}, {addr, x_addr}, {a, a});
      chk({tag, ".wdata"}, wdata | x_wdata, (k == k_wr) ? wd : 32'h0);
      chk({tag, ".busy"}, {busy, x_busy, cmd_ready, rsp_valid}, 4'b1100);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    exp = sb_q.pop_front();
    chk({tag, ".rsp_valid"}, {rsp_valid, x_rsp_valid}, 2'b11);
    chk({tag, ".rsp_data"}, rsp_data, exp.data);
    chk({tag, ".rsp_err"}, {rsp_err, x_rsp_err}, {exp.err, exp.err});
    chk({tag, ".x_rsp_data"}, x_rsp_data, exp.data);
    chk({tag, ".rsp_strobes"}, {rd_en, wr_en, addr, wdata[0]}, 0);
    if (hold > 0) begin
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 8'h00; cmd_data = 32'hDEAD_BEEF;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, ".hold_valid"}, {rsp_valid, cmd_ready, wr_en, rd_en}, 4'b1000);
        chk({tag, ".hold_data"}, rsp_data, exp.data);
        chk({tag, ".hold_cnt"}, txn_cnt, cnt[15:0]);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    cnt++;
    chk_idle_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 8'h0; cmd_data = 32'h0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset.rsp", {rsp_data, rsp_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run("wr_data", 3'd0, 8'h00, 32'hA5A5_0000, 0);
    run("wr_dir",  3'd0, 8'h04, 32'h0000_000F, 0);
    run("set_dir", 3'd2, 8'h04, 32'h0000_00F0, 0);
    run("rd_dir",  3'd1, 8'h04, 32'h0, 0);
    gpio_in = 32'h1234_5678;
    run("rd_in",   3'd1, 8'h08, 32'h0, 0);
    run("clr_data",3'd0, 8'h00, 32'h0, 0);
    run("tgl_data",3'd4, 8'h00, 32'hFFFF_FFFF, 0);
    run("rd_data", 3'd1, 8'h00, 32'h0, 0);
    run("clr_data2",3'd3, 8'h00, 32'h0F0F_0000, 0);
    run("err_clr", 3'd3, 8'h08, 32'h1, 0);
    run("err_op6", 3'd6, 8'h00, 32'h5, 0);
    run("err_op5", 3'd5, 8'h04, 32'h5, 0);
    run("err_wr",  3'd0, 8'h10, 32'h7, 0);
    run("hold",    3'd1, 8'h04, 32'h0, 5);

    // Reset in the cycle after the read strobe of a SET: the write must never happen.
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_addr = 8'h04; cmd_data = 32'h0000_0F00;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_mid.rd_en", rd_en, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    cnt = 0;
    @(negedge clk);
    chk_idle_outputs("rst_mid");
    @(posedge clk);
    #1;
    chk("rst_mid.dir", s_dir, m_dir);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_rel");
    chk("rst_rel.rsp", {rsp_data, rsp_err}, 0);
    chk("rst_rel.dir", s_dir, 32'h0000_00FF);
    run("rd_after", 3'd1, 8'h04, 32'h0, 0);

    for (int i = 0; i < 8; i++) run("wrap", 3'd7, 8'h00, 32'h0, 0);
    chk("wrap.final", {txn_cnt, 13'h0, x_txn_cnt}, {16'd9, 16'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
